sobel_ctrl: RTL and testbench

Memory-mapped sequencer for the HLS Sobel accelerator (ap_ctrl_hs protocol), attached as a slave on the tile's external xif bus. Replaces the ad-hoc one-cycle start pulse with a proper start/ready/done handshake and a sticky status register. Also provides a watchdog that resets a hung accelerator, run statistics, a level interrupt, and a lock signal that tells the image-memory decode when the accelerator owns the image buffers.

---
 rtl/sobel_ctrl.sv | 151 +++++++++++++++
 tb/tb_sobel_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_ctrl.sv
// Memory-mapped ap_ctrl_hs sequencer for the HLS Sobel accelerator: start/ready/done handshake,
// sticky status, watchdog reset, run statistics, level interrupt and image-buffer lock.
module sobel_ctrl #(
    parameter logic [31:0] BASE_ADDR      = 32'h80001000,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1048576,
    parameter int          RST_CYCLES     = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        bus_req_i,
    input  logic        bus_we_i,
    input  logic [31:0] bus_addr_bi,
    input  logic [3:0]  bus_be_bi,
    input  logic [31:0] bus_wdata_bi,
    output logic        bus_ack_o,
    output logic        bus_resp_o,
    output logic [31:0] bus_rdata_bo,
    output logic        ap_start_o,
    input  logic        ap_ready_i,
    input  logic        ap_done_i,
    input  logic        ap_idle_i,
    output logic        ap_rst_o,
    output logic        mem_lock_o,
    output logic        irq_o
);

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RST} state_t;

    localparam logic [31:0] RST_LAST = 32'(RST_CYCLES - 1);

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_runCnt;
    logic [31:0] r_cycles;
    logic [31:0] r_runs;
    logic [31:0] r_rstCnt;
    logic [31:0] r_rdata;
    logic [31:0] w_rdMux;
    logic        r_irqEn;
    logic        r_done;
    logic        r_timeout;
    logic        r_resp;
    logic        w_hit;
    logic        w_wr;
    logic        w_rd;
    logic        w_ctrlWr;
    logic        w_statWr;
    logic        w_softReq;
    logic        w_startAcc;
    logic        w_active;
    logic        w_complete;
    logic        w_watchdog;
    logic        w_unused;

    assign w_hit      = (bus_addr_bi[31:4] == BASE_ADDR[31:4]);
    assign bus_ack_o  = bus_req_i & w_hit;
    assign w_wr       = bus_ack_o & bus_we_i & bus_be_bi[0];
    assign w_rd       = bus_ack_o & ~bus_we_i;
    assign w_ctrlWr   = w_wr & (bus_addr_bi[3:2] == 2'd0);
    assign w_statWr   = w_wr & (bus_addr_bi[3:2] == 2'd1);
    assign w_unused   = ^{bus_addr_bi[1:0], bus_be_bi[3:1], bus_wdata_bi[31:3]};

    // SOFT_RST beats START in the same write; START is only honoured from IDLE.
    assign w_softReq  = w_ctrlWr & bus_wdata_bi[2] & (r_state != S_RST);
    assign w_startAcc = w_ctrlWr & bus_wdata_bi[0] & ~bus_wdata_bi[2] & (r_state == S_IDLE);
    assign w_active   = (r_state == S_START) | (r_state == S_WAIT);
    assign w_complete = ~w_softReq & (((r_state == S_START) & ap_ready_i & ap_done_i) |
                                      ((r_state == S_WAIT) & ap_done_i));
    assign w_watchdog = w_active & ~w_softReq & ~w_complete &
                        (TIMEOUT_CYCLES != 32'd0) & (r_runCnt == TIMEOUT_CYCLES);

    always_comb begin
        w_next = r_state;
        if (w_softReq) begin
            w_next = S_RST;
        end else begin
            case (r_state)
                S_IDLE:  if (w_startAcc) w_next = S_START;
                S_START: begin
                    if (w_complete)      w_next = S_IDLE;
                    else if (w_watchdog) w_next = S_RST;
                    else if (ap_ready_i) w_next = S_WAIT;
                end
                S_WAIT: begin
                    if (w_complete)      w_next = S_IDLE;
                    else if (w_watchdog) w_next = S_RST;
                end
                S_RST:   if (r_rstCnt == RST_LAST) w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_rdMux = 32'd0;
        case (bus_addr_bi[3:2])
            2'd0: w_rdMux = {30'd0, r_irqEn, 1'b0};
            2'd1: w_rdMux = {28'd0, ap_idle_i, r_timeout, r_done, (r_state != S_IDLE)};
            2'd2: w_rdMux = r_cycles;
            2'd3: w_rdMux = r_runs;
            default: w_rdMux = 32'd0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= S_IDLE;
            r_runCnt  <= 32'd0;
            r_cycles  <= 32'd0;
            r_runs    <= 32'd0;
            r_rstCnt  <= 32'd0;
            r_irqEn   <= 1'b0;
            r_done    <= 1'b0;
            r_timeout <= 1'b0;
            r_resp    <= 1'b0;
            r_rdata   <= 32'd0;
        end else begin
            r_state <= w_next;
            if (w_startAcc)
                r_runCnt <= 32'd1;
            else if (w_active && r_runCnt != 32'hFFFF_FFFF)
                r_runCnt <= r_runCnt + 32'd1;
            r_rstCnt <= (r_state == S_RST) ? r_rstCnt + 32'd1 : 32'd0;
            if (w_complete) begin
                r_cycles <= r_runCnt;
                r_runs   <= r_runs + 32'd1;
            end
            if (w_ctrlWr)
                r_irqEn <= bus_wdata_bi[1];
            // Setting a sticky flag takes priority over a same-cycle write-1-to-clear.
            if (w_complete)
                r_done <= 1'b1;
            else if (w_startAcc || (w_statWr && bus_wdata_bi[1]))
                r_done <= 1'b0;
            if (w_watchdog)
                r_timeout <= 1'b1;
            else if (w_startAcc || (w_statWr && bus_wdata_bi[2]))
                r_timeout <= 1'b0;
            r_resp  <= w_rd;
            r_rdata <= w_rd ? w_rdMux : 32'd0;
        end
    end

    assign ap_start_o   = (r_state == S_START);
    assign ap_rst_o     = rst_i | (r_state == S_RST);
    assign mem_lock_o   = (r_state != S_IDLE);
    assign irq_o        = r_irqEn & (r_done | r_timeout);
    assign bus_resp_o   = r_resp;
    assign bus_rdata_bo = r_rdata;

endmodule

// File: tb/tb_sobel_ctrl.sv
// Scoreboard testbench for sobel_ctrl: expected read data is queued when a read is issued
// and checked when bus_resp_o arrives; control outputs are checked inline per scenario.
module tb_sobel_ctrl;

    localparam logic [31:0] BASE = 32'h80001000;
    localparam logic [31:0] A_CTRL = BASE + 32'h0;
    localparam logic [31:0] A_STAT = BASE + 32'h4;
    localparam logic [31:0] A_CYC  = BASE + 32'h8;
    localparam logic [31:0] A_RUNS = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        rst;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic        bus_resp;
    logic [31:0] bus_rdata;
    logic        ap_start;
    logic        ap_ready;
    logic        ap_done;
    logic        ap_idle;
    logic        ap_rst;
    logic        mem_lock;
    logic        irq;

    int          nChecks = 0;
    int          nPass = 0;
    logic [31:0] expQ[$];
    logic [31:0] expV;
    bit          monOn = 1'b0;

    always #5 clk = ~clk;

    sobel_ctrl #(
        .BASE_ADDR(BASE),
        .TIMEOUT_CYCLES(32'd16),
        .RST_CYCLES(4)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus_req_i(bus_req),
        .bus_we_i(bus_we),
        .bus_addr_bi(bus_addr),
        .bus_be_bi(bus_be),
        .bus_wdata_bi(bus_wdata),
        .bus_ack_o(bus_ack),
        .bus_resp_o(bus_resp),
        .bus_rdata_bo(bus_rdata),
        .ap_start_o(ap_start),
        .ap_ready_i(ap_ready),
        .ap_done_i(ap_done),
        .ap_idle_i(ap_idle),
        .ap_rst_o(ap_rst),
        .mem_lock_o(mem_lock),
        .irq_o(irq)
    );

    // Response monitor: pops the scoreboard on every resp, and insists on a quiet bus otherwise.
    always @(negedge clk) begin
        if (monOn) begin
            nChecks++;
            if (bus_resp === 1'b1) begin
                if (expQ.size() == 0) begin
                    $display("[TB] FAIL unexpected_resp: got resp=1 data=%08h expected no resp", bus_rdata);
                end else begin
                    expV = expQ.pop_front();
                    if (bus_rdata !== expV)
                        $display("[TB] FAIL read_data: got %08h expected %08h", bus_rdata, expV);
                    else
                        nPass++;
                end
            end else begin
                if (bus_resp !== 1'b0 || bus_rdata !== 32'd0)
                    $display("[TB] FAIL quiet_bus: got resp=%b data=%08h expected resp=0 data=0", bus_resp, bus_rdata);
                else
                    nPass++;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: got no finish expected finish before 200000");
        $fatal(1, "[TB] simulation time limit reached");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic busWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        @(posedge clk); #1;
        bus_req = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d; bus_be = be;
        @(posedge clk); #1;
        bus_req = 1'b0; bus_we = 1'b0; bus_wdata = 32'd0;
    endtask

    task automatic busRead(input logic [31:0] a, input logic [31:0] e);
        @(posedge clk); #1;
        bus_req = 1'b1; bus_we = 1'b0; bus_addr = a; bus_be = 4'hF;
        expQ.push_back(e);
        @(posedge clk); #1;
        bus_req = 1'b0;
        @(negedge clk); #1;
        nChecks++;
        if (expQ.size() != 0) begin
            $display("[TB] FAIL read_resp_missing: got no resp at t+1 for addr %08h expected %08h", a, e);
            expQ.delete();
        end else nPass++;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        nChecks++; if (ap_start !== 1'b0) $display("[TB] FAIL rst_ap_start: got %b expected 0", ap_start); else nPass++;
        nChecks++; if (bus_ack !== 1'b0) $display("[TB] FAIL rst_ack: got %b expected 0", bus_ack); else nPass++;
        nChecks++; if (bus_resp !== 1'b0) $display("[TB] FAIL rst_resp: got %b expected 0", bus_resp); else nPass++;
        nChecks++; if (bus_rdata !== 32'd0) $display("[TB] FAIL rst_rdata: got %08h expected 0", bus_rdata); else nPass++;
        nChecks++; if (mem_lock !== 1'b0) $display("[TB] FAIL rst_lock: got %b expected 0", mem_lock); else nPass++;
        nChecks++; if (irq !== 1'b0) $display("[TB] FAIL rst_irq: got %b expected 0", irq); else nPass++;
        nChecks++; if (ap_rst !== 1'b1) $display("[TB] FAIL rst_ap_rst: got %b expected 1", ap_rst); else nPass++;
        @(posedge clk); #1;
        rst = 1'b0;
        monOn = 1'b1;
        @(negedge clk);
        nChecks++; if (ap_rst !== 1'b0) $display("[TB] FAIL rst_release: got %b expected 0", ap_rst); else nPass++;
        for (int i = 0; i < 4; i++) busRead(BASE + 32'(i * 4), 32'd0);
    endtask

    task automatic test_normal;
        busWrite(A_CTRL, 32'h3, 4'hF);
        @(negedge clk);
        nChecks++; if (ap_start !== 1'b1) $display("[TB] FAIL start_t1: got %b expected 1", ap_start); else nPass++;
        nChecks++; if (mem_lock !== 1'b1) $display("[TB] FAIL lock_t1: got %b expected 1", mem_lock); else nPass++;
        cyc(2);
        ap_ready = 1'b1;
        @(negedge clk);
        nChecks++; if (ap_start !== 1'b1) $display("[TB] FAIL start_t3: got %b expected 1", ap_start); else nPass++;
        cyc(1);
        ap_ready = 1'b0;
        @(negedge clk);
        nChecks++; if (ap_start !== 1'b0) $display("[TB] FAIL start_drop: got %b expected 0", ap_start); else nPass++;
        nChecks++; if (mem_lock !== 1'b1) $display("[TB] FAIL busy_wait: got %b expected 1", mem_lock); else nPass++;
        cyc(6);
        ap_done = 1'b1;
        @(negedge clk);
        nChecks++; if (mem_lock !== 1'b1) $display("[TB] FAIL busy_at_done: got %b expected 1", mem_lock); else nPass++;
        cyc(1);
        ap_done = 1'b0;
        @(negedge clk);
        nChecks++; if (mem_lock !== 1'b0) $display("[TB] FAIL busy_after_done: got %b expected 0", mem_lock); else nPass++;
        nChecks++; if (irq !== 1'b1) $display("[TB] FAIL irq_done: got %b expected 1", irq); else nPass++;
        busRead(A_STAT, 32'h2);
        busRead(A_CYC, 32'd10);
        busRead(A_RUNS, 32'd1);
        busRead(A_CTRL, 32'h2);
        ap_idle = 1'b1;
        busRead(A_STAT, 32'hA);
        ap_idle = 1'b0;
        busWrite(A_STAT, 32'h2, 4'hF);
        @(negedge clk);
        nChecks++; if (irq !== 1'b0) $display("[TB] FAIL irq_w1c: got %b expected 0", irq); else nPass++;
        busRead(A_STAT, 32'h0);
    endtask

    task automatic test_back_to_back;
        busWrite(A_CTRL, 32'h3, 4'hF);
        ap_ready = 1'b1; ap_done = 1'b1;
        @(negedge clk);
        nChecks++; if (irq !== 1'b0) $display("[TB] FAIL irq_during_run: got %b expected 0", irq); else nPass++;
        cyc(1);
        ap_ready = 1'b0; ap_done = 1'b0;
        @(negedge clk);
        nChecks++; if (mem_lock !== 1'b0) $display("[TB] FAIL combined_idle: got %b expected 0", mem_lock); else nPass++;
        busRead(A_CYC, 32'd1);
        busRead(A_RUNS, 32'd2);
        busWrite(A_CTRL, 32'h3, 4'hF);
        busWrite(A_CTRL, 32'h3, 4'hF);
        @(negedge clk);
        nChecks++; if (ap_start !== 1'b1) $display("[TB] FAIL busy_start_state: got %b expected 1", ap_start); else nPass++;
        ap_ready = 1'b1; ap_done = 1'b1;
        cyc(1);
        ap_ready = 1'b0; ap_done = 1'b0;
        @(negedge clk);
        nChecks++; if (mem_lock !== 1'b0) $display("[TB] FAIL busy_start_idle: got %b expected 0", mem_lock); else nPass++;
        busRead(A_CYC, 32'd3);
        busRead(A_RUNS, 32'd3);
    endtask

    task automatic test_watchdog;
        busWrite(A_CTRL, 32'h1, 4'hF);
        cyc(15);
        @(negedge clk);
        nChecks++; if (ap_rst !== 1'b0) $display("[TB] FAIL wd_early: got %b expected 0", ap_rst); else nPass++;
        nChecks++; if (mem_lock !== 1'b1) $display("[TB] FAIL wd_lock: got %b expected 1", mem_lock); else nPass++;
        cyc(1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            nChecks++; if (ap_rst !== 1'b1) $display("[TB] FAIL wd_rst_pulse%0d: got %b expected 1", i, ap_rst); else nPass++;
            cyc(1);
        end
        @(negedge clk);
        nChecks++; if (ap_rst !== 1'b0) $display("[TB] FAIL wd_rst_end: got %b expected 0", ap_rst); else nPass++;
        nChecks++; if (mem_lock !== 1'b0) $display("[TB] FAIL wd_idle: got %b expected 0", mem_lock); else nPass++;
        busRead(A_STAT, 32'h4);
        busRead(A_RUNS, 32'd3);
        busRead(A_CYC, 32'd3);
        nChecks++; if (irq !== 1'b0) $display("[TB] FAIL wd_irq_masked: got %b expected 0", irq); else nPass++;
        busWrite(A_CTRL, 32'h2, 4'hF);
        @(negedge clk);
        nChecks++; if (irq !== 1'b1) $display("[TB] FAIL wd_irq: got %b expected 1", irq); else nPass++;
        busWrite(A_STAT, 32'h4, 4'hF);
        @(negedge clk);
        nChecks++; if (irq !== 1'b0) $display("[TB] FAIL wd_irq_clear: got %b expected 0", irq); else nPass++;
    endtask

    task automatic test_soft_reset;
        busWrite(A_CTRL, 32'h1, 4'hF);
        ap_ready = 1'b1;
        cyc(1);
        ap_ready = 1'b0;
        @(negedge clk);
        nChecks++; if (ap_start !== 1'b0) $display("[TB] FAIL soft_in_wait: got %b expected 0", ap_start); else nPass++;
        busWrite(A_CTRL, 32'h4, 4'hF);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            nChecks++; if (ap_rst !== 1'b1) $display("[TB] FAIL soft_pulse%0d: got %b expected 1", i, ap_rst); else nPass++;
            cyc(1);
        end
        @(negedge clk);
        nChecks++; if (ap_rst !== 1'b0) $display("[TB] FAIL soft_end: got %b expected 0", ap_rst); else nPass++;
        nChecks++; if (mem_lock !== 1'b0) $display("[TB] FAIL soft_idle: got %b expected 0", mem_lock); else nPass++;
        busRead(A_STAT, 32'h0);
        busRead(A_RUNS, 32'd3);
        busWrite(A_CTRL, 32'h1, 4'hF);
        ap_ready = 1'b1; ap_done = 1'b1;
        cyc(1);
        ap_ready = 1'b0; ap_done = 1'b0;
        busWrite(A_CTRL, 32'h5, 4'hF);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            nChecks++; if (ap_rst !== 1'b1 || ap_start !== 1'b0)
                $display("[TB] FAIL soft5_pulse%0d: got rst=%b start=%b expected rst=1 start=0", i, ap_rst, ap_start);
            else nPass++;
            cyc(1);
        end
        @(negedge clk);
        nChecks++; if (ap_rst !== 1'b0) $display("[TB] FAIL soft5_end: got %b expected 0", ap_rst); else nPass++;
        busRead(A_STAT, 32'h2);
        busRead(A_RUNS, 32'd4);
        busRead(A_CYC, 32'd1);
    endtask

    task automatic test_decode;
        @(posedge clk); #1;
        bus_req = 1'b1; bus_we = 1'b0; bus_addr = BASE + 32'h10; bus_be = 4'hF;
        #1;
        nChecks++; if (bus_ack !== 1'b0) $display("[TB] FAIL miss_ack: got %b expected 0", bus_ack); else nPass++;
        @(posedge clk); #1;
        bus_req = 1'b0;
        cyc(2);
        @(posedge clk); #1;
        bus_req = 1'b1; bus_we = 1'b1; bus_addr = A_CTRL; bus_wdata = 32'h3; bus_be = 4'hE;
        #1;
        nChecks++; if (bus_ack !== 1'b1) $display("[TB] FAIL hit_ack: got %b expected 1", bus_ack); else nPass++;
        @(posedge clk); #1;
        bus_req = 1'b0; bus_we = 1'b0; bus_wdata = 32'd0; bus_be = 4'hF;
        @(negedge clk);
        nChecks++; if (mem_lock !== 1'b0 || ap_start !== 1'b0)
            $display("[TB] FAIL be_ignored: got lock=%b start=%b expected 0 0", mem_lock, ap_start);
        else nPass++;
        busRead(A_CTRL, 32'h0);
        busWrite(A_CYC, 32'hFFFF_FFFF, 4'hF);
        busWrite(A_RUNS, 32'h0000_1234, 4'hF);
        busRead(A_CYC, 32'd1);
        busRead(A_RUNS, 32'd4);
    endtask

    initial begin
        rst = 1'b1;
        bus_req = 1'b0; bus_we = 1'b0; bus_addr = 32'd0; bus_be = 4'hF; bus_wdata = 32'd0;
        ap_ready = 1'b0; ap_done = 1'b0; ap_idle = 1'b0;
        test_reset;
        test_normal;
        test_back_to_back;
        test_watchdog;
        test_soft_reset;
        test_decode;
        cyc(2);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
